irq_ctrl: RTL

//  Programmable interrupt controller between the device IRQ lines (timer 0, timer 1, external pin)
//  and the CPU's interrupt input. Latches per-source requests (edge or level), masks them,

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// Register bus between the CPU-side bridge and irq_ctrl.
// Single-cycle bus: a/we/wd are sampled at the rising clk edge; rd follows a combinationally.
interface irq_ctrl_if;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output a, we, wd, input rd);
  modport slave  (input a, we, wd, output rd);
endinterface

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: per-source edge/level latching, masking and
// fixed-priority selection driving a registered int_out/int_id pair to the CPU.
module irq_ctrl #(
  parameter int N_SRC = 3,
  parameter int ID_W  = 2,
  parameter int SYNC  = 1
) (
  input  logic              clk,
  input  logic              reset,
  irq_ctrl_if.slave         bus,
  input  logic [N_SRC-1:0]  irq_in,
  output logic              int_out,
  output logic [ID_W-1:0]   int_id
);

  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] mode_chg;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] wd_lo;
  logic [ID_W-1:0]  sel;
  logic             unused_wd;

  generate
    if (SYNC != 0) begin : g_sync
      logic [N_SRC-1:0] s1;
      logic [N_SRC-1:0] s2;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1 <= '0;
          s2 <= '0;
        end else begin
          s1 <= irq_in;
          s2 <= s1;
        end
      end
      assign irq_s = s2;
    end else begin : g_nosync
      assign irq_s = irq_in;
    end
  endgenerate

  assign wd_lo     = bus.wd[N_SRC-1:0];
  assign unused_wd = ^bus.wd[31:N_SRC];
  assign clr       = (bus.we && bus.a == 2'd0) ? wd_lo : '0;
  assign mode_chg  = (bus.we && bus.a == 2'd2) ? (wd_lo ^ mode) : '0;

  // Edge bits keep their latch unless cleared; a fresh edge beats W1C. A mode flip clears the bit.
  assign pend_nxt = ((mode & ((pend & ~clr) | (irq_s & ~prev))) | (~mode & irq_s)) & ~mode_chg;
  assign act      = pend & mask;

  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) sel = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= '0;
      pend    <= '0;
      mask    <= '0;
      mode    <= '0;
      int_out <= 1'b0;
      int_id  <= '0;
    end else begin
      prev <= irq_s;
      pend <= pend_nxt;
      if (bus.we && bus.a == 2'd1) mask <= wd_lo;
      if (bus.we && bus.a == 2'd2) mode <= wd_lo;
      int_out <= |act;
      if (|act) int_id <= sel;
    end
  end

  always_comb begin
    bus.rd = '0;
    case (bus.a)
      2'd0: bus.rd = {{(32-N_SRC){1'b0}}, pend};
      2'd1: bus.rd = {{(32-N_SRC){1'b0}}, mask};
      2'd2: bus.rd = {{(32-N_SRC){1'b0}}, mode};
      default: bus.rd = {int_out, {(31-ID_W){1'b0}}, int_id};
    endcase
  end

endmodule
